// File: rtl/seg_decode_fifo_pkg.sv
// Segment codes, capture-FSM states and the segment-to-BCD decoder shared by
// the seven-segment receive path.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t d;
    d       = '0;
    d.valid = 1'b1;
    case (seg)
      SEG_0:     d.digit = 4'd0;
      SEG_1:     d.digit = 4'd1;
      SEG_2:     d.digit = 4'd2;
      SEG_3:     d.digit = 4'd3;
      SEG_4:     d.digit = 4'd4;
      SEG_5:     d.digit = 4'd5;
      SEG_6:     d.digit = 4'd6;
      SEG_7:     d.digit = 4'd7;
      SEG_8:     d.digit = 4'd8;
      SEG_9:     d.digit = 4'd9;
      SEG_BLANK: begin
        d.valid = 1'b0;
        d.blank = 1'b1;
      end
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_decode_fifo_rise_edge.sv
// Registered sample of a debounced level plus a one-cycle rising-edge pulse.
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/seg_decode_fifo.sv
// Segment-pattern capture, decode and ring buffer drained by rd edges.
// Stability filter is compiled in with `define SEG_DECODE_FIFO_STABLE_EN.
//
// state | meaning
// IDLE  | seg_vld low, nothing latched
// WAIT  | pattern latched, waiting for it to prove stable
// HOLD  | pattern accepted once, ignoring it until it changes or drops
module seg_decode_fifo #(
  parameter int unsigned STABLE = 8,
  parameter int unsigned DEPTH  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       seg_vld,
  input  logic       rd,
  output logic [3:0] data_out,
  output logic       data_vld,
  output logic       empty,
  output logic       full,
  output logic       ovf,
  output logic [3:0] err_cnt
);
  import seg_pkg::*;

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 8 || STABLE == 0) begin : g_bad_param
    $error("seg_decode_fifo: DEPTH must be 2..8 and STABLE nonzero");
  end

  cap_state_t    state, state_nxt;
  logic [6:0]    seg_ref;
  logic          latch, accept, stable_done;
  logic          rd_rise, push, pop, err_inc;
  seg_dec_t      dec;
  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  rise_edge u_rd_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (rd),
    .rise  (rd_rise)
  );

`ifdef SEG_DECODE_FIFO_STABLE_EN
  localparam int unsigned SW = (STABLE > 1) ? $clog2(STABLE) : 1;
  logic [SW-1:0] stable_cnt;

  // Down-counter reloaded on every latch; terminal count marks a stable pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     stable_cnt <= '0;
    else if (latch)                                 stable_cnt <= SW'(STABLE - 1);
    else if (state == WAIT && stable_cnt != '0)     stable_cnt <= stable_cnt - 1'b1;
  end
  assign stable_done = (stable_cnt == '0);
`else
  assign stable_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      seg_ref <= '0;
    end else begin
      state <= state_nxt;
      if (latch) seg_ref <= seg_in;
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: if (seg_vld) begin
        latch     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!seg_vld)                state_nxt = IDLE;
        else if (seg_in != seg_ref)  latch     = 1'b1;
        else if (stable_done) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!seg_vld) state_nxt = IDLE;
        else if (seg_in != seg_ref) begin
          latch     = 1'b1;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dec     = seg_decode(seg_ref);
  assign push    = accept & dec.valid;
  assign err_inc = accept & ~dec.valid & ~dec.blank;
  assign pop     = rd_rise & (count != '0);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec.digit;
  end

  // A push into a full buffer drops the oldest entry unless a pop frees it first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      data_vld <= 1'b0;
      ovf      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      data_vld <= pop;
      if (pop)                 data_out <= mem[rd_ptr];
      if (push)                wr_ptr   <= ptr_inc(wr_ptr);
      if (pop || (push && full)) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop && !full) count  <= count + 1'b1;
      else if (pop && !push)     count  <= count - 1'b1;
      if (push && full && !pop)  ovf    <= 1'b1;
      if (err_inc && err_cnt != 4'hF) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_decode_fifo.sv
// Self-checking bench for seg_decode_fifo: queue-based reference model,
// per-cycle output compare, directed scenarios and a randomized phase.
module tb_seg_decode_fifo;

  localparam int STABLE = 8;
  localparam int DEPTH  = 3;
`ifdef SEG_DECODE_FIFO_STABLE_EN
  localparam int THR = STABLE + 1;
`else
  localparam int THR = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       seg_vld = 1'b0;
  logic       rd = 1'b0;
  logic [3:0] data_out;
  logic       data_vld;
  logic       empty;
  logic       full;
  logic       ovf;
  logic [3:0] err_cnt;

  always #5 clk = ~clk;

  seg_decode_fifo #(.STABLE(STABLE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .seg_vld  (seg_vld),
    .rd       (rd),
    .data_out (data_out),
    .data_vld (data_vld),
    .empty    (empty),
    .full     (full),
    .ovf      (ovf),
    .err_cnt  (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // 0..9 digit, 10 blank, -1 invalid
  function automatic int dec_model(input logic [6:0] s);
    if (s == 7'h7F) return 10;
    for (int i = 0; i < 10; i++)
      if (s == seg_codes[i]) return i;
    return -1;
  endfunction

  // Reference: a pattern is accepted exactly once, on the cycle its
  // uninterrupted valid run length reaches THR.
  int         q[$];
  int         m_dout = 0;
  int         m_err  = 0;
  int         run    = 0;
  int         m_d;
  bit         m_dvld = 0;
  bit         m_ovf  = 0;
  bit         m_rd_q = 0;
  bit         m_rise;
  bit         m_pop;
  logic [6:0] m_prev = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dout = 0; m_dvld = 0; m_ovf = 0; m_err = 0;
      run = 0; m_prev = '0; m_rd_q = 0;
    end else begin
      m_rise = rd && !m_rd_q;
      m_rd_q = rd;
      if (!seg_vld)                          run = 0;
      else if (run > 0 && seg_in == m_prev)  run++;
      else                                   run = 1;
      m_prev = seg_in;
      m_pop  = m_rise && q.size() > 0;
      m_dvld = 0;
      if (m_pop) begin
        m_dout = q.pop_front();
        m_dvld = 1;
      end
      if (run == THR) begin
        m_d = dec_model(m_prev);
        if (m_d >= 0 && m_d < 10) begin
          if (q.size() == DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1;
          end
          q.push_back(m_d);
        end else if (m_d < 0 && m_err < 15) begin
          m_err++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_data_vld", {7'd0, data_vld}, {7'd0, m_dvld});
    check("cyc_data_out", {4'd0, data_out}, 8'(m_dout));
    check("cyc_empty",    {7'd0, empty},    {7'd0, q.size() == 0});
    check("cyc_full",     {7'd0, full},     {7'd0, q.size() == DEPTH});
    check("cyc_ovf",      {7'd0, ovf},      {7'd0, m_ovf});
    check("cyc_err_cnt",  {4'd0, err_cnt},  8'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_code(input logic [6:0] code);
    seg_in  = code;
    seg_vld = 1'b1;
    tick(THR + 1);
    seg_vld = 1'b0;
    tick(1);
  endtask

  task automatic pop_expect(input string name, input bit exp_vld, input int exp_dout);
    rd = 1'b1;
    tick(1);
    check({name, "_vld"}, {7'd0, data_vld}, {7'd0, exp_vld});
    check({name, "_dout"}, {4'd0, data_out}, 8'(exp_dout));
    rd = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int pick;
    int dur;
    #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_empty", {7'd0, empty}, 8'd1);
    check("rst_full",  {7'd0, full},  8'd0);
    check("rst_dout",  {4'd0, data_out}, 8'd0);
    check("rst_err",   {4'd0, err_cnt},  8'd0);

    // single stable digit, then read it back
    seg_in = 7'h24; seg_vld = 1'b1;
    tick(10);
    seg_vld = 1'b0;
    tick(2);
    check("t1_not_empty", {7'd0, empty}, 8'd0);
    pop_expect("t1_pop", 1'b1, 2);
    check("t1_empty", {7'd0, empty}, 8'd1);

    // pattern change inside WAIT restarts the stability count
    seg_in = 7'h24; seg_vld = 1'b1;
    tick(5);
    seg_in = 7'h30;
    tick(10);
    seg_vld = 1'b0;
    tick(2);
    check("t2_err", {4'd0, err_cnt}, 8'd0);
`ifdef SEG_DECODE_FIFO_STABLE_EN
    pop_expect("t2_pop3", 1'b1, 3);
    pop_expect("t2_none", 1'b0, 3);
`else
    pop_expect("t2_pop2", 1'b1, 2);
    pop_expect("t2_pop3", 1'b1, 3);
`endif

    // invalid pattern saturates the error counter
    for (int i = 0; i < 17; i++) begin
      seg_in = 7'h7E; seg_vld = 1'b1;
      tick(9);
      seg_vld = 1'b0;
      tick(1);
    end
    check("t3_err_sat", {4'd0, err_cnt}, 8'd15);
    check("t3_empty",   {7'd0, empty},   8'd1);

    // overflow drops the oldest entry
    push_code(7'h79); push_code(7'h24); push_code(7'h30); push_code(7'h19);
    check("t4_ovf",  {7'd0, ovf},  8'd1);
    check("t4_full", {7'd0, full}, 8'd1);
    pop_expect("t4_pop_a", 1'b1, 2);
    pop_expect("t4_pop_b", 1'b1, 3);
    pop_expect("t4_pop_c", 1'b1, 4);
    pop_expect("t4_pop_d", 1'b0, 4);

    // full buffer: push and pop in the same cycle
    do_reset();
    push_code(7'h79); push_code(7'h24); push_code(7'h30);
    check("t5_full", {7'd0, full}, 8'd1);
    seg_in = 7'h12; seg_vld = 1'b1;
    tick(THR - 1);
    rd = 1'b1;
    tick(1);
    check("t5_pop_vld",  {7'd0, data_vld}, 8'd1);
    check("t5_pop_dout", {4'd0, data_out}, 8'd1);
    check("t5_ovf",      {7'd0, ovf},      8'd0);
    check("t5_full2",    {7'd0, full},     8'd1);
    seg_vld = 1'b0; rd = 1'b0;
    tick(1);
    pop_expect("t5_pop_b", 1'b1, 2);
    pop_expect("t5_pop_c", 1'b1, 3);
    pop_expect("t5_pop_d", 1'b1, 5);

    // reset during WAIT with two stored entries
    push_code(7'h78); push_code(7'h00);
    seg_in = 7'h10; seg_vld = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    check("t6_empty", {7'd0, empty},    8'd1);
    check("t6_dout",  {4'd0, data_out}, 8'd0);
    check("t6_ovf",   {7'd0, ovf},      8'd0);
    check("t6_err",   {4'd0, err_cnt},  8'd0);
    seg_vld = 1'b0;
    rst_n = 1'b1;
    tick(1);
    pop_expect("t6_pop", 1'b0, 0);

    // randomized traffic checked every cycle against the model
    for (int s = 0; s < 300; s++) begin
      pick = $urandom_range(0, 15);
      if (pick < 10)       begin seg_in = seg_codes[pick];          seg_vld = 1'b1; end
      else if (pick == 10) begin seg_in = 7'h7F;                    seg_vld = 1'b1; end
      else if (pick < 14)  begin seg_in = 7'($urandom_range(0, 127)); seg_vld = 1'b1; end
      else                 seg_vld = 1'b0;
      dur = $urandom_range(1, 14);
      for (int c = 0; c < dur; c++) begin
        rd = ($urandom_range(0, 3) == 0);
        tick(1);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    seg_vld = 1'b0; rd = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
